// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, synchronous ROM access and a small
// pc/instruction queue feeding decode. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    input  logic        id_ready_i,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cnt_o,
    output logic [31:0] fetch_cnt_o,
`endif
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic            inflight_q, inflight_d;
    logic            discard_q, discard_d;
    logic [63:0]     mem_q [DEPTH];

    logic [CntW:0]   occupancy;
    logic            push;
    logic            pop;
    logic [63:0]     head;

    // Occupancy includes the in-flight fetch so a returning response always has a free slot.
    assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign rom_ce_o   = !rst && !flush_i && (occupancy < DepthW);
    assign rom_addr_o = pc_q;

    assign push       = inflight_q && !discard_q;
    assign id_valid_o = !rst && (count_q != '0);
    assign pop        = id_valid_o && id_ready_i;

    assign head       = mem_q[rd_ptr_q];
    assign id_pc_o    = id_valid_o ? head[63:32] : 32'h0;
    assign id_inst_o  = id_valid_o ? head[31:0]  : 32'h0;

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = 1'b0;
        discard_d  = 1'b0;
        if (flush_i) begin
            pc_d      = flush_pc_i;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = inflight_q;
        end else begin
            if (rom_ce_o) begin
                pc_d       = pc_q + 32'd4;
                resp_pc_d  = pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && push) begin
            mem_q[wr_ptr_q] <= {resp_pc_q, rom_data_i};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else begin
            if (id_valid_o && !id_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (pop && !flush_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
